// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - weight-stationary tile sequencer driving the 36-bit core instruction bus
// Every inst bit comes straight from a flop; the comb block computes next-cycle state and bus.
module core_sequencer #(
  parameter int row        = 8,
  parameter int col        = 8,
  parameter int addr_width = 11,
  parameter int len_bw     = 11,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [addr_width-1:0] w_base,
  input  logic [addr_width-1:0] x_base,
  input  logic [addr_width-1:0] p_base,
  input  logic [len_bw-1:0]     num_act,
  input  logic                  ofifo_valid,
  output logic [35:0]           inst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = ((len_bw > $clog2(row + col + 1)) ? len_bw : $clog2(row + col + 1)) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [35:0] INST_IDLE = 36'h1_800C_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_WPUSH, S_GAP, S_XLOAD, S_XEXEC, S_DRAIN, S_DONE
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [len_bw-1:0]     rd_cnt, rd_n, wr_cnt, wr_n, n_q;
  logic [TW-1:0]         to_cnt, to_n;
  logic                  err_q, err_n, do_rd, do_wr;
  logic [addr_width-1:0] w_q, x_q, p_q, base;
  logic [35:0]           inst_n;
  logic                  l0_wr_n, l0_rd_n, load_n, exec_n, ofrd_n, xcen_n, pcen_n, pwen_n;
  logic [addr_width-1:0] xa_n, pa_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      to_cnt <= '0;
      err_q  <= 1'b0;
      w_q    <= '0;
      x_q    <= '0;
      p_q    <= '0;
      n_q    <= '0;
      inst   <= INST_IDLE;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rd_cnt <= rd_n;
      wr_cnt <= wr_n;
      to_cnt <= to_n;
      err_q  <= err_n;
      inst   <= inst_n;
      if (state == S_IDLE && start) begin
        w_q <= w_base;
        x_q <= x_base;
        p_q <= p_base;
        n_q <= num_act;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_n    = rd_cnt;
    wr_n    = wr_cnt;
    to_n    = to_cnt;
    err_n   = err_q;
    do_rd   = 1'b0;
    do_wr   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        err_n   = 1'b0;
        cnt_n   = '0;
        state_n = (num_act == '0) ? S_DONE : S_WLOAD;
      end
      S_WLOAD: if (cnt == CW'(row)) begin
        state_n = S_WPUSH;
        cnt_n   = '0;
      end else cnt_n = cnt + 1'b1;
      S_WPUSH: if (cnt == CW'(row + col - 1)) begin
        state_n = S_GAP;
        cnt_n   = '0;
      end else cnt_n = cnt + 1'b1;
      S_GAP: begin
        state_n = S_XLOAD;
        cnt_n   = '0;
      end
      S_XLOAD: if (cnt == CW'(n_q)) begin
        state_n = S_XEXEC;
        cnt_n   = '0;
      end else cnt_n = cnt + 1'b1;
      S_XEXEC: if (cnt + 1'b1 == CW'(n_q)) begin
        state_n = S_DRAIN;
        cnt_n   = '0;
        rd_n    = '0;
        wr_n    = '0;
        to_n    = '0;
      end else cnt_n = cnt + 1'b1;
      S_DRAIN: begin
        if (wr_cnt == n_q) begin
          state_n = S_DONE;
        end else if (!ofifo_valid && to_cnt == TW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end else begin
          to_n = ofifo_valid ? '0 : to_cnt + 1'b1;
          if (ofifo_valid && rd_cnt < n_q) begin
            do_rd = 1'b1;
            rd_n  = rd_cnt + 1'b1;
          end
          // The pmem write follows the ofifo_rd currently on the bus.
          if (inst[4]) begin
            do_wr = 1'b1;
            wr_n  = wr_cnt + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    base    = (state == S_IDLE) ? w_base : w_q;
    l0_wr_n = 1'b0;
    l0_rd_n = 1'b0;
    load_n  = 1'b0;
    exec_n  = 1'b0;
    ofrd_n  = 1'b0;
    xcen_n  = 1'b1;
    pcen_n  = 1'b1;
    pwen_n  = 1'b1;
    xa_n    = '0;
    pa_n    = '0;
    case (state_n)
      S_WLOAD: begin
        if (cnt_n < CW'(row)) begin
          xcen_n = 1'b0;
          xa_n   = base + addr_width'(cnt_n);
        end
        l0_wr_n = (cnt_n != '0);
      end
      S_XLOAD: begin
        if (cnt_n < CW'(n_q)) begin
          xcen_n = 1'b0;
          xa_n   = x_q + addr_width'(cnt_n);
        end
        l0_wr_n = (cnt_n != '0);
      end
      S_WPUSH: begin
        load_n  = 1'b1;
        l0_rd_n = 1'b1;
      end
      S_XEXEC: begin
        exec_n  = 1'b1;
        l0_rd_n = 1'b1;
      end
      S_DRAIN: begin
        ofrd_n = do_rd;
        if (do_wr) begin
          pcen_n = 1'b0;
          pwen_n = 1'b0;
          pa_n   = p_q + addr_width'(wr_cnt);
        end
      end
      default: ;
    endcase
    inst_n = {3'b000, pcen_n, pwen_n, pa_n, xcen_n, 1'b1, xa_n, 2'b00,
              ofrd_n, exec_n, load_n, l0_rd_n, l0_wr_n};
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - table-driven bench for core_sequencer
module tb_core_sequencer;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, ofifo_valid = 1'b0;
  logic [10:0] w_base = '0, x_base = '0, p_base = '0, num_act = '0;
  logic [35:0] inst;
  logic        busy, done, err;
  int          n_tests = 0, n_fail = 0;

  localparam logic [35:0] IDLE_INST = 36'h1_800C_0000;

  typedef struct {
    int w; int x; int p; int n; int mode;
    int exp_err; int exp_nwr; int exp_gap; int exp_load;
  } vec_t;
  vec_t tbl[6];

  core_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .w_base(w_base), .x_base(x_base),
    .p_base(p_base), .num_act(num_act), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [10:0] rdq[$], wrq[$], exq[$];
    int cyc = 0, l0_lag = 0, wr_lag = 0, loads = 0, execs = 0, ofrds = 0;
    int last_exec = 0, done_cyc = 0, mism = 0;
    bit prev_rd = 0, prev_of = 0, seen_done = 0;
    string t = $sformatf("v%0d_", idx);
    @(negedge clk);
    w_base = v.w[10:0]; x_base = v.x[10:0]; p_base = v.p[10:0]; num_act = v.n[10:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({t, "err_clr"}, err, 0);
    while (!seen_done && cyc < 1000) begin
      if (inst[0] !== prev_rd) l0_lag++;
      prev_rd = !inst[19];
      if (!inst[19]) rdq.push_back(inst[17:7]);
      if (inst[2] && inst[1]) loads++;
      if (inst[3] && inst[1]) begin execs++; last_exec = cyc; end
      if (!inst[32]) begin
        if (inst[31] !== 1'b0 || !prev_of) wr_lag++;
        wrq.push_back(inst[30:20]);
      end
      prev_of = inst[4];
      if (inst[4]) ofrds++;
      if (done) begin seen_done = 1; done_cyc = cyc; end
      case (v.mode)
        0: ofifo_valid = 1'b1;
        1: ofifo_valid = cyc[0];
        default: ofifo_valid = 1'b0;
      endcase
      @(negedge clk);
      cyc++;
    end
    ofifo_valid = 1'b0;
    chk({t, "done_seen"}, seen_done, 1);
    chk({t, "done_1cyc"}, done, 0);
    chk({t, "busy_end"}, busy, 0);
    chk({t, "err"}, err, v.exp_err);
    if (v.n > 0) for (int i = 0; i < 8; i++) exq.push_back(11'(v.w + i));
    for (int i = 0; i < v.n; i++) exq.push_back(11'(v.x + i));
    chk({t, "xmem_cnt"}, rdq.size(), exq.size());
    for (int i = 0; i < rdq.size() && i < exq.size(); i++) if (rdq[i] !== exq[i]) mism++;
    chk({t, "xmem_addr_mism"}, mism, 0);
    chk({t, "l0_wr_lag_err"}, l0_lag, 0);
    chk({t, "load_cycles"}, loads, v.exp_load);
    chk({t, "exec_cycles"}, execs, v.n);
    chk({t, "ofifo_rd_cnt"}, ofrds, v.exp_nwr);
    chk({t, "pmem_cnt"}, wrq.size(), v.exp_nwr);
    mism = 0;
    for (int k = 0; k < wrq.size(); k++) if (wrq[k] !== 11'(v.p + k)) mism++;
    chk({t, "pmem_addr_mism"}, mism, 0);
    chk({t, "pmem_lag_err"}, wr_lag, 0);
    if (v.exp_gap != 0) chk({t, "exec_to_done"}, done_cyc - last_exec, v.exp_gap);
  endtask

  initial begin
    tbl[0] = '{w:0,    x:8,    p:0,    n:4, mode:0, exp_err:0, exp_nwr:4, exp_gap:7,  exp_load:16};
    tbl[1] = '{w:16,   x:100,  p:50,   n:3, mode:1, exp_err:0, exp_nwr:3, exp_gap:0,  exp_load:16};
    tbl[2] = '{w:5,    x:2046, p:2047, n:4, mode:0, exp_err:0, exp_nwr:4, exp_gap:7,  exp_load:16};
    tbl[3] = '{w:0,    x:8,    p:0,    n:2, mode:2, exp_err:1, exp_nwr:0, exp_gap:65, exp_load:16};
    tbl[4] = '{w:2044, x:20,   p:10,   n:1, mode:0, exp_err:0, exp_nwr:1, exp_gap:4,  exp_load:16};
    tbl[5] = '{w:0,    x:0,    p:0,    n:0, mode:0, exp_err:0, exp_nwr:0, exp_gap:0,  exp_load:0};

    repeat (3) @(negedge clk);
    chk("rst_inst", inst, IDLE_INST);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_inst", inst, IDLE_INST);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // num_act=0 goes straight to DONE; a start seen in DONE must not launch a run
    @(negedge clk);
    num_act = 11'd0; start = 1'b1;
    @(negedge clk);
    chk("n0_done", done, 1);
    chk("n0_busy", busy, 1);
    chk("n0_inst", inst, IDLE_INST);
    num_act = 11'd4;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy", busy, 0);
    @(negedge clk);
    chk("ign_busy2", busy, 0);
    chk("ign_inst", inst, IDLE_INST);

    // asynchronous reset in the middle of XEXEC
    w_base = 11'd0; x_base = 11'd8; p_base = 11'd0; num_act = 11'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && !inst[3]; c++) @(negedge clk);
    chk("xexec_reached", inst[3], 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_inst", inst, IDLE_INST);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("after_rst_busy", busy, 0);
    chk("after_rst_inst", inst, IDLE_INST);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
